icache_refill_ctrl: RTL and testbench

Instruction-cache miss refill sequencer for the fetch stage. On a miss it issues one line-fill request to the memory side and streams the returned beats into the icache data array. It then writes the tag/valid entry of a round-robin-selected victim way. It holds fetch stalled for the whole refill and handles flushes that arrive during a refill.

---
 rtl/icache_refill_ctrl.sv | 155 +++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: one line-fill request per miss, beats streamed into
// the data array, then a tag/valid write to a round-robin victim way.
module icache_refill_ctrl #(
    parameter int PADDR_WIDTH  = 48,
    parameter int ICACHE_ASSOC = 4,
    parameter int ICACHE_SETS  = 64,
    parameter int LINE_BYTES   = 64,
    parameter int BEAT_BYTES   = 8
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst_n,
    input  logic                                                 i_miss,
    input  logic [PADDR_WIDTH-1:0]                               i_miss_paddr,
    input  logic                                                 i_flush,
    output logic                                                 o_stall,
    output logic                                                 o_mem_req_valid,
    input  logic                                                 i_mem_req_ready,
    output logic [PADDR_WIDTH-1:0]                               o_mem_req_addr,
    input  logic                                                 i_mem_resp_valid,
    input  logic [8*BEAT_BYTES-1:0]                              i_mem_resp_data,
    output logic                                                 o_data_we,
    output logic [$clog2(ICACHE_ASSOC)-1:0]                      o_data_way,
    output logic [$clog2(ICACHE_SETS)-1:0]                       o_data_index,
    output logic [$clog2(LINE_BYTES/BEAT_BYTES)-1:0]             o_data_beat,
    output logic [8*BEAT_BYTES-1:0]                              o_data_wdata,
    output logic                                                 o_tag_we,
    output logic [$clog2(ICACHE_ASSOC)-1:0]                      o_tag_way,
    output logic [$clog2(ICACHE_SETS)-1:0]                       o_tag_index,
    output logic [PADDR_WIDTH-$clog2(LINE_BYTES*ICACHE_SETS)-1:0] o_tag_ptag,
    output logic                                                 o_tag_valid,
    output logic                                                 o_refill_done
);

    localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(ICACHE_SETS);
    localparam int WAY_W  = $clog2(ICACHE_ASSOC);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int TAG_W  = PADDR_WIDTH - OFF_W - IDX_W;
    localparam int DATA_W = 8 * BEAT_BYTES;

    localparam logic [PADDR_WIDTH-1:0] OFF_MASK  = PADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BEATS - 1);

    // state  | meaning
    // IDLE   | waiting for a miss; stall only in the miss cycle itself
    // REQ    | line-fill request held until memory accepts it
    // FILL   | writing returned beats into the data array
    // TAG    | single-cycle tag/valid write, victim pointer advance
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_TAG
    } state_e;

    state_e                   state_q, state_d;
    logic [PADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WAY_W-1:0]         way_q, way_d;
    logic [WAY_W-1:0]         ptr_q, ptr_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     abort_q, abort_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            way_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            way_q   <= way_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        way_d           = way_q;
        ptr_d           = ptr_q;
        beat_d          = beat_q;
        abort_d         = abort_q;
        o_stall         = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_req_addr  = '0;
        o_data_we       = 1'b0;
        o_data_way      = '0;
        o_data_index    = '0;
        o_data_beat     = '0;
        o_data_wdata    = '0;
        o_tag_we        = 1'b0;
        o_tag_way       = '0;
        o_tag_index     = '0;
        o_tag_ptag      = '0;
        o_tag_valid     = 1'b0;
        o_refill_done   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_miss && !i_flush) begin
                    o_stall = 1'b1;
                    addr_d  = i_miss_paddr & ~OFF_MASK;
                    way_d   = ptr_q;
                    beat_d  = '0;
                    abort_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_stall         = 1'b1;
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = addr_q;
                if (i_flush) abort_d = 1'b1;
                if (i_mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                o_stall = 1'b1;
                if (i_flush) abort_d = 1'b1;
                if (i_mem_resp_valid) begin
                    o_data_we    = 1'b1;
                    o_data_way   = way_q;
                    o_data_index = addr_q[OFF_W +: IDX_W];
                    o_data_beat  = beat_q;
                    o_data_wdata = i_mem_resp_data;
                    beat_d       = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) state_d = S_TAG;
                end
            end
            S_TAG: begin
                // An aborted refill already overwrote the victim's data, so it is invalidated.
                o_stall       = 1'b1;
                o_tag_we      = 1'b1;
                o_tag_way     = way_q;
                o_tag_index   = addr_q[OFF_W +: IDX_W];
                o_tag_ptag    = addr_q[PADDR_WIDTH-1 -: TAG_W];
                o_tag_valid   = !abort_q;
                o_refill_done = !abort_q;
                ptr_d         = ptr_q + WAY_W'(1);
                abort_d       = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a transaction-level refill model checked every cycle,
// plus literal expectations on logged requests, data writes and tag writes.
module tb_icache_refill_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_miss = 1'b0;
    logic [47:0] i_miss_paddr = '0;
    logic        i_flush = 1'b0;
    logic        o_stall;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [47:0] o_mem_req_addr;
    logic        i_mem_resp_valid = 1'b0;
    logic [63:0] i_mem_resp_data = '0;
    logic        o_data_we;
    logic [1:0]  o_data_way;
    logic [5:0]  o_data_index;
    logic [2:0]  o_data_beat;
    logic [63:0] o_data_wdata;
    logic        o_tag_we;
    logic [1:0]  o_tag_way;
    logic [5:0]  o_tag_index;
    logic [35:0] o_tag_ptag;
    logic        o_tag_valid;
    logic        o_refill_done;

    icache_refill_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_miss(i_miss), .i_miss_paddr(i_miss_paddr),
        .i_flush(i_flush), .o_stall(o_stall), .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready), .o_mem_req_addr(o_mem_req_addr),
        .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_data(i_mem_resp_data),
        .o_data_we(o_data_we), .o_data_way(o_data_way), .o_data_index(o_data_index),
        .o_data_beat(o_data_beat), .o_data_wdata(o_data_wdata), .o_tag_we(o_tag_we),
        .o_tag_way(o_tag_way), .o_tag_index(o_tag_index), .o_tag_ptag(o_tag_ptag),
        .o_tag_valid(o_tag_valid), .o_refill_done(o_refill_done)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic any_out();
        return o_stall | o_mem_req_valid | (|o_mem_req_addr) | o_data_we | (|o_data_way) |
               (|o_data_index) | (|o_data_beat) | (|o_data_wdata) | o_tag_we | (|o_tag_way) |
               (|o_tag_index) | (|o_tag_ptag) | o_tag_valid | o_refill_done;
    endfunction

    // Refill model: a refill is "busy" from acceptance until its tag cycle, which is the cycle
    // after all eight beats have been counted.
    bit          m_busy = 0, m_req_done = 0, m_abort = 0;
    int          m_beats = 0, m_ptr = 0, m_way = 0;
    logic [47:0] m_addr = '0;

    int          cyc_n = 0, stall_cnt = 0;
    int          n_d = 0, n_t = 0, n_r = 0, n_acc = 0;
    int          d_beat[256], d_way[256], d_idx[256];
    logic [63:0] d_data[256];
    int          t_way[64], t_idx[64], t_valid[64], t_done[64], t_cyc[64];
    logic [35:0] t_ptag[64];
    logic [47:0] r_addr[64];
    int          acc_cyc[64];

    always @(negedge i_clk) begin
        bit accept, e_req, e_dwe, e_twe;
        cyc_n++;
        if (!i_rst_n) begin
            chk("reset_outputs_zero", 64'(any_out()), 64'd0);
            m_busy = 0; m_req_done = 0; m_abort = 0; m_beats = 0; m_ptr = 0; m_way = 0;
            m_addr = '0;
        end else begin
            accept = !m_busy && i_miss && !i_flush;
            e_req  = m_busy && !m_req_done;
            e_dwe  = m_busy && m_req_done && (m_beats < 8) && i_mem_resp_valid;
            e_twe  = m_busy && (m_beats == 8);

            chk("stall", 64'(o_stall), 64'(m_busy || accept));
            chk("req_valid", 64'(o_mem_req_valid), 64'(e_req));
            chk("req_addr", 64'(o_mem_req_addr), e_req ? 64'(m_addr) : 64'd0);
            chk("data_we", 64'(o_data_we), 64'(e_dwe));
            chk("data_way", 64'(o_data_way), e_dwe ? 64'(m_way) : 64'd0);
            chk("data_index", 64'(o_data_index), e_dwe ? 64'(m_addr[11:6]) : 64'd0);
            chk("data_beat", 64'(o_data_beat), e_dwe ? 64'(m_beats) : 64'd0);
            chk("data_wdata", o_data_wdata, e_dwe ? i_mem_resp_data : 64'd0);
            chk("tag_we", 64'(o_tag_we), 64'(e_twe));
            chk("tag_way", 64'(o_tag_way), e_twe ? 64'(m_way) : 64'd0);
            chk("tag_index", 64'(o_tag_index), e_twe ? 64'(m_addr[11:6]) : 64'd0);
            chk("tag_ptag", 64'(o_tag_ptag), e_twe ? 64'(m_addr[47:12]) : 64'd0);
            chk("tag_valid", 64'(o_tag_valid), 64'(e_twe && !m_abort));
            chk("refill_done", 64'(o_refill_done), 64'(e_twe && !m_abort));

            if (o_stall) stall_cnt++;
            if (accept) begin acc_cyc[n_acc] = cyc_n; n_acc++; end
            if (o_mem_req_valid && i_mem_req_ready) begin r_addr[n_r] = o_mem_req_addr; n_r++; end
            if (o_data_we) begin
                d_beat[n_d] = int'(o_data_beat); d_way[n_d] = int'(o_data_way);
                d_idx[n_d] = int'(o_data_index); d_data[n_d] = o_data_wdata; n_d++;
            end
            if (o_tag_we) begin
                t_way[n_t] = int'(o_tag_way); t_idx[n_t] = int'(o_tag_index);
                t_ptag[n_t] = o_tag_ptag; t_valid[n_t] = int'(o_tag_valid);
                t_done[n_t] = int'(o_refill_done); t_cyc[n_t] = cyc_n; n_t++;
            end

            if (!m_busy) begin
                if (accept) begin
                    m_busy = 1; m_req_done = 0; m_beats = 0; m_abort = 0;
                    m_addr = i_miss_paddr & ~48'h3F;
                    m_way = m_ptr;
                end
            end else if (m_beats == 8) begin
                m_busy = 0;
                m_ptr = (m_ptr + 1) % 4;
            end else begin
                if (i_flush) m_abort = 1;
                if (!m_req_done) begin
                    if (i_mem_req_ready) m_req_done = 1;
                end else if (i_mem_resp_valid) begin
                    m_beats++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic refill(input logic [47:0] pa, input int rdly, input bit gaps,
                          input int flush_beat, input logic [63:0] dbase);
        i_miss = 1'b1; i_miss_paddr = pa;
        tick();
        i_miss = 1'b0; i_miss_paddr = ~pa;
        repeat (rdly) tick();
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (gaps) repeat ((b % 2) + 1) tick();
            i_mem_resp_valid = 1'b1; i_mem_resp_data = dbase + 64'(b);
            tick();
            i_mem_resp_valid = 1'b0; i_mem_resp_data = '0;
            if (b == flush_beat) begin
                i_flush = 1'b1;
                tick();
                i_flush = 1'b0;
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int d0, t0, r0, s0;
        int exp_ways[5];
        exp_ways = '{0, 1, 2, 3, 0};

        repeat (2) tick();
        chk("init_reset_outputs", 64'(any_out()), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // Basic refill, minimum latency
        d0 = n_d; t0 = n_t; r0 = n_r; s0 = stall_cnt;
        refill(48'h0000_1234_5678, 0, 0, -1, 64'hD0D0_0000_0000_0000);
        chk("t1_req_addr", 64'(r_addr[r0]), 64'h0000_1234_5640);
        chk("t1_n_data", 64'(n_d - d0), 64'd8);
        for (int b = 0; b < 8; b++) begin
            chk("t1_beat", 64'(d_beat[d0+b]), 64'(b));
            chk("t1_index", 64'(d_idx[d0+b]), 64'h19);
            chk("t1_way", 64'(d_way[d0+b]), 64'd0);
            chk("t1_wdata", d_data[d0+b], 64'hD0D0_0000_0000_0000 + 64'(b));
        end
        chk("t1_n_tag", 64'(n_t - t0), 64'd1);
        chk("t1_ptag", 64'(t_ptag[t0]), 64'h12345);
        chk("t1_tag_valid", 64'(t_valid[t0]), 64'd1);
        chk("t1_done", 64'(t_done[t0]), 64'd1);
        chk("t1_tag_cycle", 64'(t_cyc[t0] - acc_cyc[n_acc-1]), 64'd10);
        chk("t1_stall_cycles", 64'(stall_cnt - s0), 64'd11);
        chk("t1_stall_low_after", 64'(o_stall), 64'd0);

        // Request backpressure and gapped beats
        d0 = n_d; t0 = n_t; r0 = n_r;
        refill(48'h0000_ABCD_E0C0, 3, 1, -1, 64'h2222_0000_0000_0000);
        chk("t2_n_req", 64'(n_r - r0), 64'd1);
        chk("t2_req_addr", 64'(r_addr[r0]), 64'h0000_ABCD_E0C0);
        chk("t2_n_data", 64'(n_d - d0), 64'd8);
        for (int b = 0; b < 8; b++) chk("t2_beat_order", 64'(d_beat[d0+b]), 64'(b));
        chk("t2_n_tag", 64'(n_t - t0), 64'd1);
        chk("t2_index", 64'(t_idx[t0]), 64'd3);
        chk("t2_ptag", 64'(t_ptag[t0]), 64'hABCDE);
        chk("t2_way", 64'(t_way[t0]), 64'd1);

        // Flush during FILL after beat 3
        do_reset();
        d0 = n_d; t0 = n_t;
        refill(48'h0000_0000_2FC8, 0, 0, 3, 64'h3333_0000_0000_0000);
        chk("t3_n_data", 64'(n_d - d0), 64'd8);
        chk("t3_tag_valid", 64'(t_valid[t0]), 64'd0);
        chk("t3_no_done", 64'(t_done[t0]), 64'd0);
        chk("t3_index", 64'(t_idx[t0]), 64'h3F);
        chk("t3_ptag", 64'(t_ptag[t0]), 64'h2);
        refill(48'h0000_0000_0040, 0, 0, -1, 64'h3434_0000_0000_0000);
        chk("t3_next_way", 64'(t_way[t0+1]), 64'd1);
        chk("t3_next_valid", 64'(t_valid[t0+1]), 64'd1);

        // Round-robin victim selection
        do_reset();
        t0 = n_t;
        for (int i = 0; i < 5; i++)
            refill(48'(i) * 48'h1040, 0, 0, -1, 64'h4444_0000_0000_0000 + 64'(i << 8));
        for (int i = 0; i < 5; i++) chk("t4_rr_way", 64'(t_way[t0+i]), 64'(exp_ways[i]));

        // Miss together with flush in IDLE
        r0 = n_r;
        i_miss = 1'b1; i_flush = 1'b1; i_miss_paddr = 48'h0000_5555_5555;
        #1;
        chk("t5_stall", 64'(o_stall), 64'd0);
        tick();
        i_miss = 1'b0; i_flush = 1'b0;
        #1;
        chk("t5_no_req", 64'(o_mem_req_valid), 64'd0);
        tick();
        chk("t5_n_req", 64'(n_r - r0), 64'd0);

        // Asynchronous reset in FILL after beat 4
        i_miss = 1'b1; i_miss_paddr = 48'h0000_0000_5000;
        tick();
        i_miss = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            i_mem_resp_valid = 1'b1; i_mem_resp_data = 64'h6666_0000_0000_0000 + 64'(b);
            tick();
            i_mem_resp_valid = 1'b0;
        end
        i_rst_n = 1'b0;
        #1;
        chk("t6_async_outputs", 64'(any_out()), 64'd0);
        chk("t6_stall", 64'(o_stall), 64'd0);
        d0 = n_d;
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 64'h7777_0000_0000_0005;
        repeat (2) tick();
        i_rst_n = 1'b1;
        repeat (3) tick();
        i_mem_resp_valid = 1'b0; i_mem_resp_data = '0;
        tick();
        chk("t6_no_late_writes", 64'(n_d - d0), 64'd0);
        t0 = n_t;
        refill(48'h0000_0000_9000, 0, 0, -1, 64'h8888_0000_0000_0000);
        chk("t6_way_after_reset", 64'(t_way[t0]), 64'd0);
        chk("t6_data_way", 64'(d_way[n_d-1]), 64'd0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
